// File: rtl/wb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter_if
// Bundles the requester side and the crossbar side of the Wishbone master
// arbiter into one interface.
//   m_*      : per-master request/response lanes (master k at [32k+31:32k])
//   wb_*     : the single shared crossbar master port
//   grant_o  : one-hot current owner, zero when idle
// Modports:
//   slave  : the arbiter's view (requests and crossbar responses are inputs)
//   master : the environment's view (drives requests and crossbar responses)
// ---------------------------------------------------------------------------
interface wb_master_arbiter_if #(
  parameter int MASTERS = 2
) ();

  logic [MASTERS*32-1:0] m_adr_i;
  logic [MASTERS*32-1:0] m_dat_i;
  logic [MASTERS-1:0]    m_we_i;
  logic [MASTERS-1:0]    m_stb_i;
  logic [MASTERS-1:0]    m_cyc_i;
  logic [31:0]           m_dat_o;
  logic [MASTERS-1:0]    m_ack_o;
  logic [MASTERS-1:0]    m_err_o;
  logic [31:0]           wb_adr_o;
  logic [31:0]           wb_dat_o;
  logic                  wb_we_o;
  logic                  wb_stb_o;
  logic                  wb_cyc_o;
  logic [31:0]           wb_dat_i;
  logic                  wb_ack_i;
  logic [MASTERS-1:0]    grant_o;

  modport slave (
    input  m_adr_i, m_dat_i, m_we_i, m_stb_i, m_cyc_i, wb_dat_i, wb_ack_i,
    output m_dat_o, m_ack_o, m_err_o, wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o,
           wb_cyc_o, grant_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_we_i, m_stb_i, m_cyc_i, wb_dat_i, wb_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o,
           wb_cyc_o, grant_o
  );

endinterface

// File: rtl/wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter
// Shares one Wishbone master port between MASTERS requesters. Ownership is
// decided round-robin in IDLE, registered, and held for the owner's whole
// CYC period. A watchdog ends any STB that waits TIMEOUT cycles without ACK
// by returning a one-cycle error to the owner.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : wb_master_arbiter_if.slave (request lanes, crossbar port, grant)
// ---------------------------------------------------------------------------
module wb_master_arbiter #(
  parameter int MASTERS = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_master_arbiter_if.slave  bus
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [IW-1:0]      owner;
  logic [31:0]        own_adr;
  logic [31:0]        own_dat;
  logic               own_we;
  logic               own_stb;
  logic               own_cyc;

  logic [IW-1:0]      winner;
  logic               any_req;

  logic               req_stb;
  logic               timeout;

  // Owner lane selected straight from the one-hot grant; all zero when idle.
  always_comb begin
    owner   = '0;
    own_adr = '0;
    own_dat = '0;
    own_we  = 1'b0;
    own_stb = 1'b0;
    own_cyc = 1'b0;
    for (int k = 0; k < MASTERS; k++) begin
      if (grant_q[k]) begin
        owner   = IW'(k);
        own_adr = bus.m_adr_i[32*k +: 32];
        own_dat = bus.m_dat_i[32*k +: 32];
        own_we  = bus.m_we_i[k];
        own_stb = bus.m_stb_i[k];
        own_cyc = bus.m_cyc_i[k];
      end
    end
  end

  // Round-robin search from last+1. Walking the offsets downwards lets the
  // nearest requester (smallest offset) overwrite the farther ones.
  always_comb begin
    int          cand;
    logic [IW-1:0] cidx;
    winner  = '0;
    any_req = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      cand = int'(last_q) + k;
      if (cand >= MASTERS) cand = cand - MASTERS;
      cidx = IW'(cand);
      if (bus.m_cyc_i[cidx]) begin
        winner  = cidx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = '0;
    req_stb      = 1'b0;
    timeout      = 1'b0;
    bus.wb_adr_o = '0;
    bus.wb_dat_o = '0;
    bus.wb_we_o  = 1'b0;
    bus.wb_cyc_o = 1'b0;
    bus.wb_stb_o = 1'b0;
    bus.m_ack_o  = '0;
    bus.m_err_o  = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d         = BUSY;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
        end
      end

      BUSY: begin
        req_stb = own_cyc & own_stb;
        // ACK in the final wait cycle wins over the timeout.
        timeout = req_stb & ~bus.wb_ack_i & (cnt_q == CNT_LAST);

        bus.wb_adr_o = own_adr;
        bus.wb_dat_o = own_dat;
        bus.wb_we_o  = own_we;
        bus.wb_cyc_o = own_cyc;
        bus.wb_stb_o = req_stb & ~timeout;
        bus.m_ack_o  = grant_q & bus.m_stb_i & {MASTERS{bus.wb_ack_i}};
        bus.m_err_o  = grant_q & {MASTERS{timeout}};

        if (req_stb && !bus.wb_ack_i && !timeout) cnt_d = cnt_q + CW'(1);

        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign bus.m_dat_o = bus.wb_dat_i;
  assign bus.grant_o = grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_master_arbiter
// Directed scenarios followed by randomized traffic for wb_master_arbiter.
// A behavioural model (owner index, last owner, consecutive unanswered STB
// cycles) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_wb_master_arbiter;

  localparam int MASTERS = 3;
  localparam int TIMEOUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wb_master_arbiter_if #(.MASTERS(MASTERS)) bus ();

  wb_master_arbiter #(
    .MASTERS(MASTERS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // stimulus
  logic [MASTERS-1:0] cyc, stb, we;
  logic [31:0]        adr [MASTERS];
  logic [31:0]        dat [MASTERS];
  logic               ack;
  logic [31:0]        rdat;

  // reference model state: owner (-1 = nobody), last owner, waited cycles
  int own, lst, wt;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply();
    for (int m = 0; m < MASTERS; m++) begin
      bus.m_adr_i[32*m +: 32] = adr[m];
      bus.m_dat_i[32*m +: 32] = dat[m];
    end
    bus.m_cyc_i  = cyc;
    bus.m_stb_i  = stb;
    bus.m_we_i   = we;
    bus.wb_ack_i = ack;
    bus.wb_dat_i = rdat;
  endtask

  task automatic model_reset();
    own = -1;
    lst = MASTERS - 1;
    wt  = 0;
  endtask

  // Expected outputs for the current inputs and model state.
  task automatic check_model();
    logic [MASTERS-1:0] e_gnt, e_ack, e_err;
    logic [31:0]        e_adr, e_dat;
    logic               e_we, e_cyc, e_stb, req, tmo;
    e_gnt = '0; e_ack = '0; e_err = '0;
    e_adr = '0; e_dat = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
    if (own >= 0) begin
      req          = cyc[own] && stb[own];
      tmo          = req && !ack && (wt == TIMEOUT - 1);
      e_gnt[own]   = 1'b1;
      e_cyc        = cyc[own];
      e_stb        = req && !tmo;
      e_ack[own]   = ack && stb[own];
      e_err[own]   = tmo;
      e_adr        = adr[own];
      e_dat        = dat[own];
      e_we         = we[own];
    end
    chk("grant_o",  64'(bus.grant_o),  64'(e_gnt));
    chk("wb_cyc_o", 64'(bus.wb_cyc_o), 64'(e_cyc));
    chk("wb_stb_o", 64'(bus.wb_stb_o), 64'(e_stb));
    chk("wb_we_o",  64'(bus.wb_we_o),  64'(e_we));
    chk("wb_adr_o", 64'(bus.wb_adr_o), 64'(e_adr));
    chk("wb_dat_o", 64'(bus.wb_dat_o), 64'(e_dat));
    chk("m_ack_o",  64'(bus.m_ack_o),  64'(e_ack));
    chk("m_err_o",  64'(bus.m_err_o),  64'(e_err));
    chk("m_dat_o",  64'(bus.m_dat_o),  64'(rdat));
  endtask

  // Called at posedge+1: drive, let logic settle, compare (still before negedge).
  task automatic settle();
    apply();
    #3;
    check_model();
  endtask

  // Advance the model using the inputs of the finishing cycle, then clock.
  task automatic tick();
    int  nown, nlst, nwt, c;
    bit  req, tmo;
    nown = own; nlst = lst; nwt = 0;
    if (own < 0) begin
      for (int k = 1; k <= MASTERS; k++) begin
        c = (lst + k) % MASTERS;
        if (nown < 0 && cyc[c]) nown = c;
      end
    end else if (!cyc[own]) begin
      nown = -1;
      nlst = own;
    end else begin
      req = cyc[own] && stb[own];
      tmo = req && !ack && (wt == TIMEOUT - 1);
      nwt = (req && !ack && !tmo) ? wt + 1 : 0;
    end
    @(posedge clk);
    #1;
    own = nown; lst = nlst; wt = nwt;
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0; ack = 1'b0; rdat = '0;
    for (int m = 0; m < MASTERS; m++) begin
      adr[m] = '0;
      dat[m] = '0;
    end
  endtask

  initial begin
    clear_inputs();
    apply();
    model_reset();

    // reset state
    #2;
    chk("rst_grant", 64'(bus.grant_o),  64'(0));
    chk("rst_cyc",   64'(bus.wb_cyc_o), 64'(0));
    chk("rst_stb",   64'(bus.wb_stb_o), 64'(0));
    chk("rst_adr",   64'(bus.wb_adr_o), 64'(0));
    chk("rst_ack",   64'(bus.m_ack_o),  64'(0));
    chk("rst_err",   64'(bus.m_err_o),  64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    settle(); tick();

    // master0 write, ACK after three wait cycles
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    adr[0] = 32'h0000_0104; dat[0] = 32'hDEAD_BEEF;
    settle();
    chk("wr_idle_cyc", 64'(bus.wb_cyc_o), 64'(0));
    tick();
    settle();
    chk("wr_cyc_rise", 64'(bus.wb_cyc_o), 64'(1));
    chk("wr_adr",      64'(bus.wb_adr_o), 64'h104);
    chk("wr_dat",      64'(bus.wb_dat_o), 64'hDEAD_BEEF);
    tick();
    settle(); tick();
    ack = 1'b1;
    settle();
    chk("wr_ack", 64'(bus.m_ack_o), 64'b001);
    tick();
    ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    settle();
    chk("wr_cyc_drop", 64'(bus.wb_cyc_o), 64'(0));
    tick();
    settle();
    chk("wr_grant_idle", 64'(bus.grant_o), 64'(0));
    tick();

    // read from master1
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h0000_0200;
    settle(); tick();
    ack = 1'b1; rdat = 32'h1234_5678;
    settle();
    chk("rd_dat", 64'(bus.m_dat_o), 64'h1234_5678);
    chk("rd_ack", 64'(bus.m_ack_o), 64'b010);
    tick();
    ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    settle(); tick();
    settle(); tick();

    // watchdog: STB with no ACK errors in the TIMEOUT-th STB cycle
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'hBAD0_0000;
    settle(); tick();
    for (int k = 1; k <= TIMEOUT; k++) begin
      settle();
      chk("tmo_err",  64'(bus.m_err_o[0]), 64'(k == TIMEOUT));
      chk("tmo_stb",  64'(bus.wb_stb_o),   64'(k != TIMEOUT));
      chk("tmo_ack",  64'(bus.m_ack_o),    64'(0));
      tick();
    end
    // STB still high: counter restarted; ACK lands in the timeout cycle
    for (int k = 1; k <= TIMEOUT; k++) begin
      ack = (k == TIMEOUT);
      settle();
      chk("tmo2_err", 64'(bus.m_err_o), 64'(0));
      if (k == TIMEOUT) chk("tmo2_ack", 64'(bus.m_ack_o), 64'b001);
      tick();
    end
    ack = 1'b0;

    // asynchronous reset in the middle of a pending STB
    settle();
    chk("pre_rst_cyc", 64'(bus.wb_cyc_o), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc",   64'(bus.wb_cyc_o), 64'(0));
    chk("arst_stb",   64'(bus.wb_stb_o), 64'(0));
    chk("arst_grant", 64'(bus.grant_o),  64'(0));
    chk("arst_ack",   64'(bus.m_ack_o),  64'(0));
    chk("arst_err",   64'(bus.m_err_o),  64'(0));
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // simultaneous requests from masters 0 and 1: grants 0, 1, 0
    cyc = 3'b011; stb = 3'b011; adr[1] = 32'h0000_0300;
    settle(); tick();
    settle();
    chk("rr_first", 64'(bus.grant_o), 64'b001);
    tick();
    cyc[0] = 1'b0; stb[0] = 1'b0;
    settle();
    chk("rr_hold", 64'(bus.grant_o), 64'b001);
    tick();
    settle();
    chk("rr_gap", 64'(bus.grant_o), 64'(0));
    tick();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    settle();
    chk("rr_second", 64'(bus.grant_o), 64'b010);
    tick();
    cyc[1] = 1'b0; stb[1] = 1'b0;
    settle(); tick();
    settle(); tick();
    settle();
    chk("rr_third", 64'(bus.grant_o), 64'b001);
    tick();
    clear_inputs();
    settle(); tick();
    settle(); tick();

    // randomized traffic: frequent ACKs, rare ACKs, then no ACKs at all
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < MASTERS; m++) begin
        if (cyc[m]) begin
          if ($urandom_range(0, 9) == 0) cyc[m] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          cyc[m] = 1'b1;
        end
        stb[m] = cyc[m] & ($urandom_range(0, 3) != 0);
        we[m]  = 1'($urandom_range(0, 1));
        adr[m] = $urandom;
        dat[m] = $urandom;
      end
      if (n < 1500)      ack = ($urandom_range(0, 2) == 0);
      else if (n < 2500) ack = ($urandom_range(0, 15) == 0);
      else               ack = 1'b0;
      rdat = $urandom;
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
